// File: rtl/lap_stopwatch.sv
// Stopwatch with per-button debounce, prescaled saturating counter and a
// show-ahead lap FIFO drained by the host. Single clock domain.
module lap_stopwatch #(
    parameter int WIDTH     = 32,
    parameter int DEBOUNCE  = 3,
    parameter int PRESCALE  = 1,
    parameter int LAP_DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic                       i_stop,
    input  logic                       i_lap,
    input  logic                       i_lap_rd,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_running,
    output logic                       o_overflow,
    output logic [WIDTH-1:0]           o_lap_data,
    output logic                       o_lap_valid,
    output logic [$clog2(LAP_DEPTH):0] o_lap_count,
    output logic                       o_lap_drop
);

    localparam int NB   = 3;
    localparam int DB_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
    localparam int PS_W = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);
    localparam int AW   = $clog2(LAP_DEPTH);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);
    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ONE    = PS_W'(1);
    localparam logic [AW:0]     PTR_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]     FIFO_FULL = (AW + 1)'(LAP_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } state_t;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + WIDTH'(1);
    endfunction

    logic [NB-1:0]   btn_raw;
    logic [NB-1:0]   btn_wait;
    logic [NB-1:0]   btn_pulse;
    logic [DB_W-1:0] btn_cnt [NB];

    state_t           state_q, state_d;
    logic             start_p, stop_p, lap_p;
    logic             clear, lap_push;
    logic [PS_W-1:0]  psc_q;
    logic [WIDTH-1:0] cnt_q, cnt_next;
    logic             ovf_q;

    logic [WIDTH-1:0] lap_mem [LAP_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, lap_cnt;
    logic             fifo_empty, fifo_full, do_pop, do_push, do_drop;
    logic             drop_q;

    assign btn_raw = {i_lap, i_stop, i_start};
    assign {lap_p, stop_p, start_p} = btn_pulse;

    // btn_wait=0 hunts for DEBOUNCE highs (press), btn_wait=1 for DEBOUNCE lows (release)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_wait  <= '0;
            btn_pulse <= '0;
            for (int b = 0; b < NB; b++) btn_cnt[b] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                btn_pulse[b] <= 1'b0;
                if (btn_raw[b] == btn_wait[b]) begin
                    btn_cnt[b] <= '0;
                end else if (btn_cnt[b] == DB_LAST) begin
                    btn_cnt[b]   <= '0;
                    btn_wait[b]  <= ~btn_wait[b];
                    btn_pulse[b] <= ~btn_wait[b];
                end else begin
                    btn_cnt[b] <= btn_cnt[b] + DB_ONE;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        clear    = 1'b0;
        lap_push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_p && !stop_p) state_d = ST_RUN;
            end
            ST_RUN: begin
                lap_push = lap_p;
                if (stop_p && !start_p) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (start_p && !stop_p) begin
                    state_d = ST_RUN;
                end else if (stop_p && !start_p) begin
                    state_d = ST_IDLE;
                    clear   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cnt_next = sat_inc(cnt_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            psc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear) begin
            psc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (state_q == ST_RUN) begin
            if (psc_q == PS_LAST) begin
                psc_q <= '0;
                cnt_q <= cnt_next;
                if (&cnt_next) ovf_q <= 1'b1;
            end else begin
                psc_q <= psc_q + PS_ONE;
            end
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
    assign lap_cnt    = wr_ptr - rd_ptr;
    assign fifo_empty = (lap_cnt == '0);
    assign fifo_full  = (lap_cnt == FIFO_FULL);
    assign do_pop     = i_lap_rd && !fifo_empty;
    assign do_push    = lap_push && (!fifo_full || do_pop);
    assign do_drop    = lap_push && fifo_full && !do_pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            drop_q <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            drop_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_drop) drop_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !clear) lap_mem[wr_ptr[AW-1:0]] <= cnt_q;
    end

    assign o_data      = cnt_q;
    assign o_running   = (state_q == ST_RUN);
    assign o_overflow  = ovf_q;
    assign o_lap_data  = fifo_empty ? '0 : lap_mem[rd_ptr[AW-1:0]];
    assign o_lap_valid = !fifo_empty;
    assign o_lap_count = lap_cnt;
    assign o_lap_drop  = drop_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: three parameterisations share one set of buttons;
// lap captures go through a scoreboard queue and are checked as they are popped.
`timescale 1ns/1ps
module tb_lap_stopwatch;

    localparam int DB        = 3;
    localparam int RUN_EDGE  = DB + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, stop, lap, lap_rd;

    logic [31:0] d_data, d_lap_data;
    logic        d_running, d_overflow, d_lap_valid, d_lap_drop;
    logic [2:0]  d_lap_count;

    logic [15:0] p_data, p_lap_data;
    logic        p_running, p_overflow, p_lap_valid, p_lap_drop;
    logic [2:0]  p_lap_count;

    logic [3:0]  s_data, s_lap_data;
    logic        s_running, s_overflow, s_lap_valid, s_lap_drop;
    logic [2:0]  s_lap_count;

    lap_stopwatch #(.WIDTH(32), .DEBOUNCE(DB), .PRESCALE(1), .LAP_DEPTH(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_lap(lap),
        .i_lap_rd(lap_rd), .o_data(d_data), .o_running(d_running), .o_overflow(d_overflow),
        .o_lap_data(d_lap_data), .o_lap_valid(d_lap_valid), .o_lap_count(d_lap_count),
        .o_lap_drop(d_lap_drop)
    );

    lap_stopwatch #(.WIDTH(16), .DEBOUNCE(DB), .PRESCALE(4), .LAP_DEPTH(4)) u_psc (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_lap(lap),
        .i_lap_rd(lap_rd), .o_data(p_data), .o_running(p_running), .o_overflow(p_overflow),
        .o_lap_data(p_lap_data), .o_lap_valid(p_lap_valid), .o_lap_count(p_lap_count),
        .o_lap_drop(p_lap_drop)
    );

    lap_stopwatch #(.WIDTH(4), .DEBOUNCE(DB), .PRESCALE(1), .LAP_DEPTH(4)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_lap(lap),
        .i_lap_rd(lap_rd), .o_data(s_data), .o_running(s_running), .o_overflow(s_overflow),
        .o_lap_data(s_lap_data), .o_lap_valid(s_lap_valid), .o_lap_count(s_lap_count),
        .o_lap_drop(s_lap_drop)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    int          edge_n   = 0;
    logic [31:0] lap_q[$];
    logic [31:0] cap, exp_v;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            edge_n++;
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        lap    = 1'b0;
        lap_rd = 1'b0;
        tick(2);
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    task automatic drain_laps(input string tag);
        while (lap_q.size() > 0) begin
            exp_v = lap_q.pop_front();
            check_val({tag, "_valid"}, d_lap_valid, 1);
            check_val({tag, "_head"}, d_lap_data, exp_v);
            lap_rd = 1'b1;
            tick(1);
            lap_rd = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        rst_n = 1'b0;
        tick(1);
        check_val("rst_data", d_data, 0);
        check_val("rst_running", d_running, 0);
        check_val("rst_overflow", d_overflow, 0);
        check_val("rst_lap_valid", d_lap_valid, 0);
        check_val("rst_lap_count", d_lap_count, 0);
        check_val("rst_lap_data", d_lap_data, 0);
        check_val("rst_lap_drop", d_lap_drop, 0);

        // Press latency and single press while held (PRESCALE=1)
        do_reset();
        start = 1'b1;
        tick(DB);
        check_val("lat_running_e3", d_running, 0);
        tick(1);
        check_val("lat_running_e4", d_running, 1);
        check_val("lat_data_e4", d_data, 0);
        tick(1);
        check_val("lat_data_e5", d_data, 1);
        tick(9);
        check_val("lat_data_e14", d_data, 10);
        tick(6);
        check_val("held_start_data_e20", d_data, 16);
        start = 1'b0;
        stop  = 1'b1;
        tick(DB + 1);
        check_val("stop_running", d_running, 0);
        check_val("stop_data", d_data, 20);
        tick(16);
        check_val("held_stop_single_press", d_data, 20);
        stop = 1'b0;
        tick(DB);
        lap = 1'b1;
        tick(DB + 1);
        lap = 1'b0;
        tick(DB);
        check_val("lap_in_hold_ignored", d_lap_count, 0);

        // Short glitches never make a press
        do_reset();
        start = 1'b1; tick(2);
        start = 1'b0; tick(1);
        start = 1'b1; tick(2);
        start = 1'b0; tick(5);
        check_val("glitch_running", d_running, 0);
        check_val("glitch_data", d_data, 0);

        // Prescaler: one count per 4 RUN cycles, hold, resume, clear
        do_reset();
        start = 1'b1;
        tick(DB + 1);
        check_val("psc_running", p_running, 1);
        start = 1'b0;
        tick(36);
        check_val("psc_data_e40", p_data, 9);
        stop = 1'b1;
        tick(DB);
        check_val("psc_data_e43", p_data, 9);
        tick(1);
        check_val("psc_data_e44", p_data, 10);
        check_val("psc_hold_running", p_running, 0);
        stop = 1'b0;
        tick(16);
        check_val("psc_hold_data", p_data, 10);
        start = 1'b1;
        tick(DB + 1);
        check_val("psc_resume_running", p_running, 1);
        start = 1'b0;
        tick(3);
        check_val("psc_resume_e67", p_data, 10);
        tick(1);
        check_val("psc_resume_e68", p_data, 11);
        stop = 1'b1;
        tick(DB + 1);
        check_val("psc_hold2_data", p_data, 12);
        stop = 1'b0;
        tick(DB + 1);
        stop = 1'b1;
        tick(DB + 1);
        check_val("psc_clear_data", p_data, 0);
        check_val("psc_clear_running", p_running, 0);
        stop = 1'b0;
        tick(DB);

        // Lap FIFO: fill, overflow drop, drain in order, empty pops
        do_reset();
        start = 1'b1;
        tick(DB + 1);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            // Lap acts DB+1 edges after rising; it captures the count from the edge before
            cap = edge_n + DB - RUN_EDGE;
            if (i < 4) lap_q.push_back(cap);
            lap = 1'b1;
            tick(DB + 1);
            lap = 1'b0;
            if (i == 0) begin
                check_val("lap_first_valid", d_lap_valid, 1);
                check_val("lap_first_head", d_lap_data, cap);
            end
            if (i == 3) check_val("lap_drop_before_full", d_lap_drop, 0);
            tick(DB);
        end
        check_val("lap_count_full", d_lap_count, 4);
        check_val("lap_drop_set", d_lap_drop, 1);
        drain_laps("lap_pop");
        check_val("lap_drained_count", d_lap_count, 0);
        check_val("lap_drained_valid", d_lap_valid, 0);
        check_val("lap_drained_data", d_lap_data, 0);
        lap_rd = 1'b1;
        tick(1);
        lap_rd = 1'b0;
        check_val("lap_empty_pop_count", d_lap_count, 0);
        check_val("lap_drop_sticky", d_lap_drop, 1);
        cap = edge_n + DB - RUN_EDGE;
        lap_q.push_back(cap);
        lap = 1'b1;
        tick(DB);
        lap_rd = 1'b1;
        tick(1);
        lap_rd = 1'b0;
        lap = 1'b0;
        check_val("lap_push_pop_empty_count", d_lap_count, 1);
        tick(DB);
        drain_laps("lap_pp");
        check_val("lap_pp_count", d_lap_count, 0);

        // Saturation on a 4-bit counter
        do_reset();
        start = 1'b1;
        tick(DB + 1);
        start = 1'b0;
        tick(14);
        check_val("sat_data_e18", s_data, 14);
        check_val("sat_ovf_e18", s_overflow, 0);
        tick(1);
        check_val("sat_data_e19", s_data, 15);
        check_val("sat_ovf_e19", s_overflow, 1);
        tick(5);
        check_val("sat_data_held", s_data, 15);
        check_val("sat_still_running", s_running, 1);
        stop = 1'b1; tick(DB + 1);
        stop = 1'b0; tick(DB);
        check_val("sat_hold_ovf", s_overflow, 1);
        stop = 1'b1; tick(DB + 1);
        check_val("sat_clear_data", s_data, 0);
        check_val("sat_clear_ovf", s_overflow, 0);
        check_val("sat_clear_running", s_running, 0);
        stop = 1'b0; tick(DB);

        // Asynchronous reset mid-run with two laps stored
        do_reset();
        start = 1'b1;
        tick(DB + 1);
        start = 1'b0;
        repeat (2) begin
            lap = 1'b1; tick(DB + 1);
            lap = 1'b0; tick(DB);
        end
        check_val("arst_pre_count", d_lap_count, 2);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_data", d_data, 0);
        check_val("arst_running", d_running, 0);
        check_val("arst_overflow", d_overflow, 0);
        check_val("arst_lap_data", d_lap_data, 0);
        check_val("arst_lap_valid", d_lap_valid, 0);
        check_val("arst_lap_count", d_lap_count, 0);
        check_val("arst_lap_drop", d_lap_drop, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check_val("arst_after_count", d_lap_count, 0);
        check_val("arst_after_valid", d_lap_valid, 0);
        check_val("arst_after_running", d_running, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
